// File: rtl/dram_arb_pkg.sv
// Shared definitions for the DRAM arbiter: default widths, FSM state
// encoding and width helpers used by the top, the pick logic and the
// bus interface.
package dram_arb_pkg;

    localparam int NUM_REQ_DEF       = 2;
    localparam int ADDR_W_DEF        = 13;
    localparam int DATA_W_DEF        = 64;
    localparam int START_TIMEOUT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Width of the counter that measures how long busy takes to rise.
    function automatic int tcnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    localparam int TCNT_W_DEF = tcnt_width(START_TIMEOUT_DEF);

endpackage

// File: rtl/dram_arbiter_if.sv
// Bundles the requester-side and DRAM-side signals of the arbiter.
// The arbiter uses the slave modport; the environment (clients plus
// DRAM) uses the master modport.
interface dram_arbiter_if
    import dram_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) ();

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        ack;
    logic                      err;
    logic [DATA_W-1:0]         rdata;

    logic                      mem_start;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_we;
    logic [DATA_W-1:0]         mem_wdata;
    logic                      mem_busy;
    logic [DATA_W-1:0]         mem_rdata;

    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_busy, mem_rdata,
        output gnt, ack, err, rdata, mem_start, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req, req_we, req_addr, req_wdata, mem_busy, mem_rdata,
        input  gnt, ack, err, rdata, mem_start, mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request bit at or after
// the pointer, wrapping around. The pointer itself is owned by the caller.
module rr_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int PTR_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);

    // Scan from the pointer position and keep the first hit only.
    always_comb begin
        int                 pos;
        logic [PTR_W-1:0]   cand;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        pos  = 0;
        cand = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            cand = PTR_W'(pos);
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter and sequencer sharing one DRAM between several
// single-word requesters. Captures the winner's request, pulses the DRAM
// start, follows busy to completion (or gives up if busy never rises)
// and returns an ack, plus read data for reads.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_REQ       = NUM_REQ_DEF,
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    dram_arbiter_if.slave   bus
);

    localparam int PTR_W  = idx_width(NUM_REQ);
    localparam int TCNT_W = tcnt_width(START_TIMEOUT);

    arb_state_t          state;
    arb_state_t          state_nxt;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_any;

    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    win_idx;
    logic [NUM_REQ-1:0]  gnt_r;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W-1:0]   rdata_r;
    logic                seen_busy;
    logic                timed_out;
    logic [TCNT_W-1:0]   tcnt;

    logic                start_c;
    logic [NUM_REQ-1:0]  ack_c;
    logic                err_c;
    logic                busy_done;
    logic                busy_timeout;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req (bus.req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Busy went high and has now dropped: the access is finished.
    assign busy_done    = seen_busy && !bus.mem_busy;
    // Busy has not risen within the allowed window after start.
    assign busy_timeout = !seen_busy && !bus.mem_busy &&
                          (tcnt == TCNT_W'(START_TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the single-cycle start/ack/err strobes.
    always_comb begin
        state_nxt = state;
        start_c   = 1'b0;
        ack_c     = '0;
        err_c     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any && !bus.mem_busy) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                start_c   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (busy_done || busy_timeout) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ack_c     = gnt_r;
                err_c     = timed_out;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, busy tracking, read data capture and pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            win_idx   <= '0;
            gnt_r     <= '0;
            we_r      <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= '0;
            rdata_r   <= '0;
            seen_busy <= 1'b0;
            timed_out <= 1'b0;
            tcnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_nxt == ISSUE) begin
                        gnt_r   <= pick_gnt;
                        win_idx <= pick_idx;
                        we_r    <= bus.req_we[pick_idx];
                        addr_r  <= bus.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        wdata_r <= bus.req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                    end
                end
                ISSUE: begin
                    seen_busy <= 1'b0;
                    timed_out <= 1'b0;
                    tcnt      <= '0;
                end
                WAIT: begin
                    if (bus.mem_busy) begin
                        seen_busy <= 1'b1;
                    end else if (!seen_busy) begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                    if (busy_timeout) begin
                        timed_out <= 1'b1;
                    end
                    if (busy_done && !we_r) begin
                        rdata_r <= bus.mem_rdata;
                    end
                end
                DONE: begin
                    gnt_r <= '0;
                    we_r  <= 1'b0;
                    if (win_idx == PTR_W'(NUM_REQ - 1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= win_idx + PTR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.ack       = ack_c;
    assign bus.err       = err_c;
    assign bus.rdata     = rdata_r;
    assign bus.mem_start = start_c;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_we    = we_r;
    assign bus.mem_wdata = wdata_r;

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one DRAM instance among NUM_REQ requesters.
- Each requester presents a single-word read or write request. The arbiter captures the request, issues the DRAM start pulse and tracks the DRAM busy signal to completion.
- On completion it returns an ack pulse, and read data for reads.
- Sits between client engines (DMA, CPU port) and the DRAM model.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 13, DRAM word address width.
- DATA_W, 64, data width.
- START_TIMEOUT, 4, maximum cycles after start that busy may take to rise before the access is aborted.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req  in  NUM_REQ  per-requester request level.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened write data, same packing.
- gnt  out  NUM_REQ  one-hot; high for the whole transaction of the winner.
- ack  out  NUM_REQ  one-cycle completion pulse to the winner.
- err  out  1  one-cycle pulse alongside ack when the access timed out.
- rdata  out  DATA_W  read data; valid in the ack cycle and held until the next read completes.
- mem_start  out  1  DRAM start pulse.
- mem_addr  out  ADDR_W  DRAM address.
- mem_we  out  1  DRAM write enable.
- mem_wdata  out  DATA_W  DRAM write data.
- mem_busy  in  1  DRAM busy.
- mem_rdata  in  DATA_W  DRAM data out.

Behaviour:
- Reset (rst high at a posedge):
  - State returns to IDLE.
  - gnt, ack, err, mem_start, mem_we = 0; mem_addr, mem_wdata, rdata = 0.
  - Round-robin pointer = 0, so requester 0 has top priority.
  - Reset mid-transaction abandons the transaction without an ack; rst also resets the DRAM.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req bit is set, pick the winner: the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Register gnt, and latch the winner's we/addr/wdata into mem_we/mem_addr/mem_wdata. Go to ISSUE.
  - With no request, stay in IDLE with all outputs quiet.
- ISSUE:
  - mem_start = 1 for exactly this one cycle.
  - Clear the seen_busy flag and the timeout counter. Go to WAIT.
- WAIT:
  - Set seen_busy when mem_busy = 1.
  - Go to DONE when seen_busy = 1 and mem_busy = 0.
  - If mem_busy is never seen within START_TIMEOUT cycles of entering WAIT, go to DONE with the timeout flag set.
  - mem_addr, mem_we and mem_wdata stay stable throughout WAIT.
- DONE:
  - ack[winner] = 1 for one cycle; err = timeout flag.
  - For a read without timeout, rdata <= mem_rdata, sampled on the first cycle mem_busy is low. rdata is unchanged on writes and timeouts.
  - gnt clears at the end of DONE. The pointer moves to winner+1 mod NUM_REQ. Return to IDLE.
- Latency: first DRAM start occurs 2 cycles after req is sampled in IDLE. Arbiter overhead is 3 cycles beyond the DRAM busy window.
- Request rules:
  - req is level-sensitive. The requester holds req and its payload stable until granted.
  - req may drop before grant; it is then simply not selected.
  - Changes to req or payload after grant are ignored, because the payload is already latched.
  - Holding req through ack means a new request. It is served only after other pending requesters get a turn.
- Simultaneous requests: exactly one gnt bit is ever high. A requester waits at most NUM_REQ-1 transactions.
- The arbiter never issues mem_start while mem_busy is high, or while in WAIT or DONE.

Decomposition:
- Package dram_arb_pkg holds:
  - ADDR_W/DATA_W defaults;
  - the state enum (IDLE, ISSUE, WAIT, DONE);
  - the timeout counter width, clog2(START_TIMEOUT+1).
- Sub-module rr_arbiter: purely the combinational pick (req vector + pointer -> one-hot grant). The pointer register lives in the top.

Test Plan:
1. Single requester: write addr 0x0000 data 42 from req0, then read 0x0000 -> one mem_start per access, ack[0] pulses, rdata = 42, err = 0.
2. Contention: req0 and req1 assert in the same cycle after reset, both writing (0x1020 = 56 and 0x0010 = 7) -> req0 is served first, then req1. Reads back return 56 and 7. gnt is never two-hot.
3. Fairness: req0 held continuously, req1 asserted -> grants alternate 0, 1, 0, 1. req1 waits at most one transaction.
4. Boundary address: write 0x1FFF = 23, read 0x1FFF -> rdata = 23. mem_addr is stable throughout WAIT.
5. Timeout: DRAM stub holds busy low after start -> ack and err pulse START_TIMEOUT+1 cycles after ISSUE, rdata unchanged, and the next request proceeds normally.
6. Reset mid-WAIT: assert rst during a read -> no ack, all outputs 0 next cycle, pointer = 0. A fresh request then completes correctly.
